// File: rtl/ttm4_pkg.sv
// Shared types and constants for the TTM4 firmware loader / fetch sequencer.
// Holds the sequencer state enum, default bus widths and the TTM4
// instruction field positions (OP 14:10, SR 9:7, LR 6:4, IM 3:0).
package ttm4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fw_state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_WORD_W = 15;

  localparam int OP_HI = 14;
  localparam int OP_LO = 10;
  localparam int SR_HI = 9;
  localparam int SR_LO = 7;
  localparam int LR_HI = 6;
  localparam int LR_LO = 4;
  localparam int IM_HI = 3;
  localparam int IM_LO = 0;

endpackage

// File: rtl/fw_loader_seq_if.sv
// Host-side bundle for the firmware loader: load/run requests, the program
// word stream, and the memory-facing PA / IO / strobe outputs plus status.
// Suffixes are from the sequencer's point of view (slave modport).
interface fw_loader_seq_if import ttm4_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W
) ();

  logic              load_req_i;
  logic [ADDR_W:0]   load_len_i;
  logic              wr_valid_i;
  logic [WORD_W-1:0] wr_data_i;
  logic              wr_ready_o;
  logic              run_req_i;
  logic              loop_i;
  logic              hold_i;
  logic              abort_i;
  logic [ADDR_W-1:0] pa_o;
  logic [WORD_W-1:0] io_out_o;
  logic              io_oe_o;
  logic              n_we_o;
  logic              n_oe_o;
  logic [ADDR_W:0]   words_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport slave (
    input  load_req_i, load_len_i, wr_valid_i, wr_data_i,
    input  run_req_i, loop_i, hold_i, abort_i,
    output wr_ready_o, pa_o, io_out_o, io_oe_o, n_we_o, n_oe_o,
    output words_o, busy_o, done_o, err_o
  );

  modport master (
    output load_req_i, load_len_i, wr_valid_i, wr_data_i,
    output run_req_i, loop_i, hold_i, abort_i,
    input  wr_ready_o, pa_o, io_out_o, io_oe_o, n_we_o, n_oe_o,
    input  words_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/fw_checksum_acc.sv
// Running mod-2^16 sum of program words accepted during a load.
// Only built when FW_LOADER_CHECKSUM_EN is defined.
`ifdef FW_LOADER_CHECKSUM_EN
module fw_checksum_acc import ttm4_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [15:0]       sum_o
);

  logic [15:0] sum_q;
  logic [15:0] sum_d;

  // Clear on a new load, otherwise add each accepted word (zero-extended or truncated to 16 bits).
  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + 16'(data_i);
    end
  end

  // Accumulator register; the sum lands together with the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule
`endif

// File: rtl/fw_loader_seq.sv
// Firmware loader and fetch sequencer for the TTM4 MEMORY block.
// LOAD writes streamed words to consecutive program addresses; RUN replays
// fetch addresses from 0 with hold, optional looping and abort.
// Optional checksum output is enabled by defining FW_LOADER_CHECKSUM_EN.
module fw_loader_seq import ttm4_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FW_LOADER_CHECKSUM_EN
  output logic [15:0] chksum_o,
`endif
  fw_loader_seq_if.slave bus
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  fw_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] pa_q, pa_d;
  logic [WORD_W-1:0] io_out_q, io_out_d;
  logic              io_oe_q, io_oe_d;
  logic              n_we_q, n_we_d;
  logic              n_oe_q, n_oe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              loop_q, loop_d;
  logic              len_ok;
  logic [ADDR_W-1:0] last_pa;

  assign len_ok  = (bus.load_len_i != '0) && (bus.load_len_i <= MAX_LEN);
  assign last_pa = ADDR_W'(words_q - 1'b1);

  // Next-state and output decode; strobes default to inactive every cycle.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    words_d  = words_q;
    pa_d     = pa_q;
    io_out_d = io_out_q;
    io_oe_d  = 1'b0;
    n_we_d   = 1'b1;
    n_oe_d   = 1'b1;
    done_d   = 1'b0;
    err_d    = err_q;
    loop_d   = loop_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_req_i) begin
          if (len_ok) begin
            state_d = LOAD;
            addr_d  = '0;
            len_d   = bus.load_len_i;
            words_d = '0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.run_req_i) begin
          if (words_q == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            loop_d  = bus.loop_i;
            err_d   = 1'b0;
            pa_d    = '0;
            n_oe_d  = 1'b0;
          end
        end
      end
      LOAD: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (bus.wr_valid_i) begin
          pa_d     = addr_q;
          io_out_d = bus.wr_data_i;
          io_oe_d  = 1'b1;
          n_we_d   = 1'b0;
          addr_d   = addr_q + 1'b1;
          words_d  = words_q + 1'b1;
          if (words_q + 1'b1 == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (bus.hold_i) begin
          n_oe_d = n_oe_q;
        end else if (pa_q == last_pa) begin
          if (loop_q) begin
            pa_d   = '0;
            n_oe_d = 1'b0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          pa_d   = pa_q + 1'b1;
          n_oe_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      words_q  <= '0;
      pa_q     <= '0;
      io_out_q <= '0;
      io_oe_q  <= 1'b0;
      n_we_q   <= 1'b1;
      n_oe_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      loop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      words_q  <= words_d;
      pa_q     <= pa_d;
      io_out_q <= io_out_d;
      io_oe_q  <= io_oe_d;
      n_we_q   <= n_we_d;
      n_oe_q   <= n_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      loop_q   <= loop_d;
    end
  end

  assign bus.wr_ready_o = (state_q == LOAD) && !bus.abort_i;
  assign bus.pa_o       = pa_q;
  assign bus.io_out_o   = io_out_q;
  assign bus.io_oe_o    = io_oe_q;
  assign bus.n_we_o     = n_we_q;
  assign bus.n_oe_o     = n_oe_q;
  assign bus.words_o    = words_q;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

`ifdef FW_LOADER_CHECKSUM_EN
  logic beat;
  logic load_start;

  assign beat       = (state_q == LOAD) && !bus.abort_i && bus.wr_valid_i;
  assign load_start = (state_q == IDLE) && bus.load_req_i && len_ok;

  fw_checksum_acc #(.WORD_W(WORD_W)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .clear_i (load_start),
    .en_i    (beat),
    .data_i  (bus.wr_data_i),
    .sum_o   (chksum_o)
  );
`endif

endmodule

// File: doc/fw_loader_seq.md
Name: fw_loader_seq

Overview:
Synthesizable, parametrised successor to the hand-driven firmware-load and fetch sequence used around the TTM4 MEMORY block. It has two modes:
- Load: accepts program words on a valid/ready stream and writes them to program memory at consecutive addresses.
- Run: replays fetch addresses from 0, with hold, optional looping and abort.
It sits between a host/stream source and the MEMORY/REGISTERS PA and IO buses.

Parameters:
ADDR_W, 8, program address width; memory depth is 2^ADDR_W words.
WORD_W, 15, instruction word width (OP, SR, LR, IM fields).

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST  in  1  synchronous reset, active-high.
LOAD_REQ  in  1  start load; sampled in IDLE only.
LOAD_LEN  in  ADDR_W+1  word count for the load; valid range 1..2^ADDR_W.
WR_VALID  in  1  stream word valid.
WR_DATA  in  WORD_W  stream word.
WR_READY  out  1  stream ready; combinational: (state==LOAD) && !ABORT.
RUN_REQ  in  1  start fetch replay; sampled in IDLE only.
LOOP  in  1  sampled at RUN_REQ accept; 1 = wrap to address 0 after the last word.
HOLD  in  1  freeze PA during RUN.
ABORT  in  1  return to IDLE.
PA  out  ADDR_W  program address to memory (registered).
IO_OUT  out  WORD_W  write data (registered).
IO_OE  out  1  1 = drive IO bus with IO_OUT; 0 = release (tristate at top level).
nWE  out  1  memory write strobe, active-low.
nOE  out  1  memory read enable, active-low.
WORDS  out  ADDR_W+1  number of words held from the last load.
BUSY  out  1  state != IDLE.
DONE  out  1  one-cycle completion pulse.
ERR  out  1  sticky request error.

Behaviour:
- Reset values: state IDLE; PA=0; IO_OUT=0; IO_OE=0; nWE=1; nOE=1; WORDS=0; DONE=0; ERR=0. An address counter is 0.
- The reset check has top priority. RST asserted mid-load or mid-run goes to IDLE next edge. WORDS=0 after reset.
- States are IDLE, LOAD, RUN.
- IDLE + LOAD_REQ:
  - LOAD_LEN in range: go to LOAD, clear addr, latch LOAD_LEN, clear ERR, set WORDS=0.
  - LOAD_LEN out of range: stay in IDLE, set ERR=1.
  - LOAD_REQ has priority over a simultaneous RUN_REQ, which is ignored.
- LOAD:
  - A beat accepted at cycle t (WR_VALID && WR_READY) produces at t+1: PA=addr, IO_OUT=WR_DATA, IO_OE=1, nWE=0 for exactly one cycle. addr and WORDS each increment.
  - Back-to-back beats give back-to-back strobes. Idle cycles give nWE=1 and IO_OE=0.
  - When the LOAD_LEN-th beat is accepted at t: at t+1 state is IDLE, WR_READY=0, DONE=1 (coincides with the final strobe).
  - Address LOAD_LEN = 2^ADDR_W fills the memory; addr wraps to 0 internally, with no extra write.
- IDLE + RUN_REQ:
  - WORDS==0: set ERR=1, no state change.
  - Otherwise: go to RUN, latch LOOP, clear ERR. The cycle after accept: nOE=0, PA=0.
- RUN:
  - Each cycle PA increments, except while HOLD=1 (PA and nOE frozen).
  - After PA=WORDS-1 has been presented for one non-held cycle:
    - LOOP=1: PA=0 next cycle, continuing indefinitely.
    - LOOP=0: nOE=1, state IDLE, DONE=1.
  - nWE=1 and IO_OE=0 throughout RUN.
- ABORT (LOAD or RUN):
  - Next cycle: IDLE, nWE=1, nOE=1, IO_OE=0, no DONE.
  - A beat coincident with ABORT is not accepted.
  - WORDS keeps the count of words actually written.
- ABORT in IDLE has no effect.

Optional Feature:
FW_LOADER_CHECKSUM_EN:
- Defined: adds output CHKSUM[15:0], the mod-2^16 sum of zero-extended (WORD_W ≤ 16) or truncated words accepted in the current/last load. It is cleared at LOAD_REQ accept and at reset, and updated at t+1 with the strobe.
- Undefined: the port and logic are absent.

Decomposition:
- Package ttm4_pkg holds:
  - the fw_state_t enum (IDLE, LOAD, RUN);
  - default ADDR_W/WORD_W constants;
  - TTM4 field offsets (OP 14:10, SR 9:7, LR 6:4, IM 3:0).
- One natural sub-module: fw_checksum_acc (accumulator, compiled under the macro).

Test Plan:
- Load 5 words {00000_000_000_0000, 00001_010_000_0010, 10100_010_010_0011, 00001_111_000_0100, 01100_000_000_0000} back-to-back, LOAD_LEN=5 -> nWE low on 5 consecutive cycles, PA 0..4 with matching IO_OUT; DONE on the 5th strobe; WORDS=5; CHKSUM=16'h8DA9 (with macro).
- RUN_REQ with LOOP=0 after the above -> nOE=0 with PA 0,1,2,3,4 on consecutive cycles, then nOE=1, DONE 1 cycle, BUSY=0. With HOLD=1 for 2 cycles at PA=2 -> PA=2 held 3 cycles total.
- LOOP=1 run of 5 words -> PA sequence 0..4,0..4,…; ABORT at PA=3 -> next cycle nOE=1, BUSY=0, no DONE.
- LOAD_LEN=0 or 257 (ADDR_W=8) -> ERR=1, BUSY stays 0; RUN_REQ with WORDS=0 -> ERR=1; next valid LOAD_REQ clears ERR.
- Load with WR_VALID gaps plus ABORT after 3 beats, coincident with a 4th valid beat -> 3 strobes only, WORDS=3, WR_READY=0 during ABORT.
- RST asserted mid-load (after 2 beats) -> next cycle all outputs at reset values, WORDS=0.
